// File: rtl/fib_table_reader.sv
// Reads a Fibonacci table (entries 0..n) once the generator is ready and streams it over valid/ready.
// Each entry is checked against the recurrence; the first failing index is kept until the next start.
module fib_table_reader #(
  parameter int                 DATA_W = 32,
  parameter int                 ADDR_W = 6,
  parameter logic [DATA_W-1:0]  SEED0  = '0,
  parameter logic [DATA_W-1:0]  SEED1  = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] n,
  input  logic              fib_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_index
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_GEN = 3'd1,
    S_READ     = 3'd2,
    S_SEND     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_n_lat;
  logic [DATA_W-1:0] r_prev1;
  logic [DATA_W-1:0] r_prev2;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_index;
  logic              r_err;
  logic [ADDR_W-1:0] r_err_index;

  logic [DATA_W-1:0] w_expected;
  logic [DATA_W-1:0] w_sum;
  logic              w_mismatch;
  logic              w_last;
  logic              w_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_xfer = r_out_valid && out_ready;
  assign w_last = (r_idx == r_n_lat);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_WAIT_GEN;
      S_WAIT_GEN:     if (fib_ready) w_state_nxt = S_READ;
      S_READ:         w_state_nxt = S_SEND;
      S_SEND:         if (w_xfer) w_state_nxt = w_last ? S_DONE : S_READ;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Sum wraps at DATA_W bits: the table is defined modulo 2^DATA_W.
  assign w_sum = r_prev1 + r_prev2;

  always_comb begin
    w_expected = w_sum;
    if (r_idx == '0)                w_expected = SEED0;
    else if (r_idx == ADDR_W'(1))   w_expected = SEED1;
  end

  assign w_mismatch = (mem_data != w_expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_n_lat     <= '0;
      r_prev1     <= '0;
      r_prev2     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_err       <= 1'b0;
      r_err_index <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_n_lat     <= n;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_err_index <= '0;
          end
        end
        S_READ: begin
          r_out_data  <= mem_data;
          r_out_index <= r_idx;
          r_out_valid <= 1'b1;
          // History tracks the table's actual contents, not the expected values.
          r_prev2     <= r_prev1;
          r_prev1     <= mem_data;
          if (w_mismatch && !r_err) begin
            r_err       <= 1'b1;
            r_err_index <= r_idx;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            r_out_valid <= 1'b0;
            if (!w_last) r_idx <= r_idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // idx is 0 while waiting and holds the last index in DONE.
  assign mem_addr  = r_idx;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign err       = r_err;
  assign err_index = r_err_index;
  assign busy      = (r_state == S_WAIT_GEN) || (r_state == S_READ) || (r_state == S_SEND);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_fib_table_reader.sv
// Self-checking bench for fib_table_reader: directed scenarios plus randomized tables,
// stalls and generator delays, checked against a recurrence model over the memory contents.
module tb_fib_table_reader;
  localparam int DW = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst, start, fib_ready, out_ready;
  logic [AW-1:0] n;
  logic [AW-1:0] mem_addr, out_index, err_index;
  logic [DW-1:0] mem_data, out_data;
  logic          out_valid, busy, done, err;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] got [64];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign mem_data = mem[mem_addr];

  fib_table_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .fib_ready(fib_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .busy(busy), .done(done), .err(err), .err_index(err_index)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void fill_fib();
    mem[0] = 0;
    mem[1] = 1;
    for (int i = 2; i < 64; i++) mem[i] = mem[i-1] + mem[i-2];
  endfunction

  // First index in 0..last whose stored value breaks the seed/recurrence rule, else -1.
  function automatic int first_bad(input int last);
    logic [DW-1:0] e;
    for (int i = 0; i <= last; i++) begin
      if (i == 0)      e = 0;
      else if (i == 1) e = 1;
      else             e = mem[i-1] + mem[i-2];
      if (mem[i] !== e) return i;
    end
    return -1;
  endfunction

  // mode: 0 = always ready, 1 = random ready, 2 = 3-cycle stall on index 2
  task automatic run(input int nn, input int dly, input int mode, input bit extra_start);
    int cyc, exp_idx, fe, first_v, last_t, stall_left;
    bit fin, stalled, bad_now;
    logic [DW-1:0] held;
    fe = first_bad(nn);
    stall_left = (mode == 2) ? 3 : 0;
    exp_idx = 0; first_v = -1; last_t = -1; fin = 0; stalled = 0; held = '0;
    @(negedge clk);
    start = 1; n = AW'(nn); fib_ready = (dly == 0); out_ready = 0;
    @(negedge clk);
    start = 0;
    cyc = 1;
    while (!fin && cyc < 3000) begin
      if (dly > 0 && cyc == dly) fib_ready = 1;
      if (extra_start) begin
        start = (cyc == 2);
        n = AW'(9);
      end
      if (cyc <= ((dly > 0) ? dly : 1))
        chk("wait_gen", {busy, out_valid, mem_addr}, {1'b1, 1'b0, AW'(0)});
      if (out_valid && first_v < 0) begin
        first_v = cyc;
        chk("first_valid_cyc", cyc, (dly == 0) ? 3 : dly + 2);
      end
      if (stalled) chk("stall_hold", {out_valid, out_data}, {1'b1, held});
      if (mode == 0)      out_ready = 1;
      else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else begin
        out_ready = !(out_valid && out_index == 2 && stall_left > 0);
        if (!out_ready) stall_left--;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid) begin
        bad_now = (fe >= 0) && (fe <= int'(out_index));
        chk("err_flag", err, bad_now);
        if (bad_now) chk("err_index", err_index, fe);
      end
      if (out_valid && out_ready) begin
        chk("out_index", out_index, exp_idx);
        chk("out_data", out_data, mem[exp_idx]);
        got[exp_idx] = out_data;
        if (mode == 0 && last_t >= 0) chk("xfer_gap", cyc - last_t, 2);
        last_t = cyc;
        exp_idx++;
      end
      if (done) fin = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 0;
    chk("done_seen", fin, 1);
    chk("xfer_count", exp_idx, nn + 1);
    chk("done_state", {busy, out_valid, mem_addr}, {1'b0, 1'b0, AW'(nn)});
    chk("final_err", err, fe >= 0);
    if (fe >= 0) chk("final_err_idx", err_index, fe);
  endtask

  initial begin
    int cnt, k, nn;
    rst = 1; start = 0; n = '0; fib_ready = 0; out_ready = 0;
    fill_fib();
    repeat (3) @(negedge clk);
    chk("reset_outs", {out_valid, busy, done, err, mem_addr, out_index, err_index}, '0);
    chk("reset_data", out_data, '0);
    rst = 0;

    // Clean table, full throughput
    run(5, 0, 0, 0);
    // Stall on index 2
    run(5, 0, 2, 0);
    // Corrupted word 4; index 5 also mismatches but first index is kept
    mem[4] = 4;
    run(5, 0, 0, 0);
    fill_fib();
    // n=0, late generator, ignored start while busy
    run(0, 5, 0, 1);
    // Long table with wrap-around
    run(50, 0, 0, 0);
    chk("f48_wrap", got[48], 64'd512559680);

    // Reset while index 3 is offered
    fib_ready = 1; out_ready = 1;
    @(negedge clk); start = 1; n = 5;
    @(negedge clk); start = 0;
    cnt = 0;
    while (!(out_valid && out_index == 3) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("reach_idx3", cnt < 100, 1);
    rst = 1;
    #1;
    chk("rst_async", {out_valid, busy, done, err, mem_addr, out_index, err_index}, '0);
    chk("rst_async_data", out_data, '0);
    @(negedge clk); rst = 0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_after_rst", {out_valid, busy, done}, '0);
    end
    run(5, 0, 1, 0);

    // Randomized tables, lengths, delays and backpressure
    for (int t = 0; t < 8; t++) begin
      fill_fib();
      nn = $urandom_range(0, 20);
      k = $urandom_range(0, 20);
      if ($urandom_range(0, 1) == 1) mem[k] = mem[k] ^ (32'($urandom) | 32'd1);
      run(nn, $urandom_range(0, 4), $urandom_range(0, 2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fib_table_reader.md
Name: fib_table_reader

Overview:
Downstream consumer of the Fibonacci generator/memory stage. It waits for the generator's ready flag, then reads table entries 0..n from the memory read port. It streams each entry out over a valid/ready handshake and checks, on the fly, that the table obeys the Fibonacci recurrence (modulo 2^32). It reports completion and the first failing index.

Parameters:
DATA_W, 32, width of table entries and output data
ADDR_W, 6, width of memory address, n and index
SEED0, 0, required value at index 0
SEED1, 1, required value at index 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to read a table; honoured only in IDLE or DONE
n  in  ADDR_W  last index to read; sampled on accepted start
fib_ready  in  1  generator has finished writing the table
mem_addr  out  ADDR_W  memory read address
mem_data  in  DATA_W  memory read data, combinational from mem_addr (same cycle)
out_valid  out  1  out_data/out_index are valid
out_ready  in  1  downstream accepts the transfer when high with out_valid
out_data  out  DATA_W  table entry
out_index  out  ADDR_W  index of out_data
busy  out  1  high in WAIT_GEN, READ and SEND
done  out  1  level; high in DONE until the next accepted start or reset
err  out  1  sticky recurrence or seed mismatch flag; cleared on accepted start
err_index  out  ADDR_W  index of the first mismatch since the last start

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; all outputs 0; internal idx, n_lat, prev1, prev2 set to 0.
- FSM states: IDLE, WAIT_GEN, READ, SEND, DONE.
- IDLE/DONE + start: latch n_lat=n, idx=0, clear err, err_index and done, then go to WAIT_GEN. Outside IDLE and DONE, start is ignored.
- WAIT_GEN: mem_addr=0. Go to READ on the first cycle fib_ready=1. If fib_ready is already 1, that is the cycle after start. Later fib_ready deassertion is ignored.
- READ (exactly 1 cycle): mem_addr=idx.
  - At the clock edge, capture out_data=mem_data and out_index=idx, assert out_valid, and go to SEND.
- Checker, evaluated on the READ capture value v:
  - idx=0: compare v to SEED0.
  - idx=1: compare v to SEED1.
  - idx>=2: compare v to (prev1+prev2) mod 2^DATA_W; the carry is discarded.
  - On mismatch with err=0: set err=1 and err_index=idx. Later mismatches do not change err_index. Streaming continues.
  - After each check: prev2<=prev1, prev1<=v. The table's actual value is used, not the expected one.
- SEND: out_valid held high with stable out_data/out_index until the cycle out_valid and out_ready are both high.
  - On that transfer, if idx==n_lat: out_valid<=0 and go to DONE.
  - Otherwise: idx<=idx+1, out_valid<=0, and go to READ.
- Throughput: with out_ready tied high, one entry every 2 cycles. The first out_valid rises 2 cycles after start when fib_ready=1.
- Entry count is n_lat+1. For n=0, one entry. For n=2^ADDR_W-1, the last index is compared before increment, so idx never wraps.
- busy=1 in WAIT_GEN, READ and SEND. done=1 only in DONE. In DONE, mem_addr holds the last index.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A partially streamed table is abandoned and a new start is required.

Test Plan:
- Memory holds 0,1,1,2,3,5; n=5; fib_ready=1; out_ready=1 -> 6 transfers with out_index 0..5 and out_data 0,1,1,2,3,5; transfers every 2 cycles; done=1; err=0.
- Same table, out_ready held low for 3 cycles while index 2 is offered -> out_valid stays 1 and out_data stays 1 for the whole stall; all 6 values are still delivered in order.
- Memory word 4 = 4 (expected 3), n=5 -> err=1 and err_index=4 after index 4 is read; index 5 (5) also mismatches (expected 4+2) but err_index stays 4; all 6 entries are still streamed.
- n=0 with fib_ready asserted 5 cycles after start -> mem_addr=0 while waiting; single transfer (0, index 0); done=1; a second start while busy has no effect.
- n=50 with a correct table -> F(48) reads 512559680 (4807526976 mod 2^32) and err stays 0; 51 transfers; done=1.
- rst pulsed while index 3 is in SEND -> all outputs 0 asynchronously; state IDLE; no further transfers until a new start, which reads from index 0.
